// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops one word per frame from an upstream FIFO and serialises it
//            as 8N1-style UART (start, DATA_W bits LSB first, stop).
//            Define UART_PARITY_EN to insert an even-parity bit before STOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tx_enable,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rd_data,
  output logic              o_fifo_rd_en,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int c_CW = $clog2(CLKS_PER_BIT);
  localparam int c_BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_BW-1:0] c_BIT_MAX = c_BW'(DATA_W - 1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_FETCH  = 3'd1;
  localparam logic [2:0] c_ST_LOAD   = 3'd2;
  localparam logic [2:0] c_ST_START  = 3'd3;
  localparam logic [2:0] c_ST_DATA   = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = 3'd5;
`endif
  localparam logic [2:0] c_ST_STOP   = 3'd6;

  logic [2:0]        r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [c_BW-1:0]   r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;
  logic              r_armed;
`ifdef UART_PARITY_EN
  logic              r_parity;
  logic              w_parity_nxt;
`endif

  logic [2:0]        w_next_state;
  logic              w_cnt_last;
  logic              w_timed;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic [c_BW-1:0]   w_bit_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_tx_nxt;
  logic              w_rd_en_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  assign w_cnt_last = (r_cnt == c_CNT_MAX);

  // r_armed holds off the first FETCH until the second edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_armed  <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_rd_en  <= w_rd_en_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_armed  <= 1'b1;
`ifdef UART_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (r_armed && i_tx_enable && !i_fifo_empty) w_next_state = c_ST_FETCH;
      c_ST_FETCH: w_next_state = c_ST_LOAD;
      c_ST_LOAD:  w_next_state = c_ST_START;
      c_ST_START: if (w_cnt_last) w_next_state = c_ST_DATA;
      c_ST_DATA: begin
        if (w_cnt_last && (r_bit == c_BIT_MAX)) begin
`ifdef UART_PARITY_EN
          w_next_state = c_ST_PARITY;
`else
          w_next_state = c_ST_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      c_ST_PARITY: if (w_cnt_last) w_next_state = c_ST_STOP;
`endif
      c_ST_STOP:  if (w_cnt_last) w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state so the registers line up with it.
  always_comb begin
    w_timed = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
`ifdef UART_PARITY_EN
              (r_state == c_ST_PARITY) ||
`endif
              (r_state == c_ST_STOP);

    w_cnt_nxt = '0;
    if (w_timed && (w_next_state == r_state) && !w_cnt_last)
      w_cnt_nxt = r_cnt + c_CW'(1);

    w_bit_nxt = '0;
    if (r_state == c_ST_DATA) begin
      w_bit_nxt = r_bit;
      if (w_cnt_last)
        w_bit_nxt = (r_bit == c_BIT_MAX) ? '0 : r_bit + c_BW'(1);
    end

    w_shift_nxt = r_shift;
    if (r_state == c_ST_LOAD)
      w_shift_nxt = i_fifo_rd_data;
    else if ((r_state == c_ST_DATA) && w_cnt_last)
      w_shift_nxt = r_shift >> 1;

`ifdef UART_PARITY_EN
    w_parity_nxt = r_parity;
    if (r_state == c_ST_LOAD)
      w_parity_nxt = ^i_fifo_rd_data;
`endif

    case (w_next_state)
      c_ST_START:  w_tx_nxt = 1'b0;
      c_ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_PARITY_EN
      c_ST_PARITY: w_tx_nxt = w_parity_nxt;
`endif
      default:     w_tx_nxt = 1'b1;
    endcase

    w_rd_en_nxt = (w_next_state == c_ST_FETCH);
    w_busy_nxt  = (w_next_state != c_ST_IDLE);
    w_done_nxt  = (w_next_state == c_ST_STOP) && (w_cnt_nxt == c_CNT_MAX);
  end

  assign o_fifo_rd_en = r_rd_en;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the FIFO word and UART data width.
REQ-002 Parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), SHALL set clk cycles per serial bit; legal range is 2 or more.
REQ-003 clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 tx_enable  in  1  1 = allowed to start new frames.
REQ-006 fifo_empty  in  1  upstream FIFO holds no words.
REQ-007 fifo_rd_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 fifo_rd_en  out  1  one-cycle pop strobe to the FIFO read enable.
REQ-009 tx  out  1  UART serial line, idle high.
REQ-010 busy  out  1  frame in progress, from FETCH through STOP.
REQ-011 frame_done  out  1  one-cycle pulse on the last cycle of STOP.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, PARITY, STOP; all outputs registered.
REQ-013 In IDLE with tx_enable=1 and fifo_empty=0, the block SHALL go to FETCH and drive fifo_rd_en=1 for exactly that one cycle.
REQ-014 In LOAD (next cycle), the block SHALL capture fifo_rd_data into a DATA_W shift register, then go to START.
REQ-015 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA SHALL send DATA_W bits LSB first, each held CLKS_PER_BIT cycles; bit counter 0..DATA_W-1.
REQ-017 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; frame_done=1 in the final STOP cycle.
REQ-018 After STOP, the block SHALL go to IDLE; if the start condition holds there, FETCH SHALL follow on the next cycle (one IDLE cycle between frames).
REQ-019 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits, count 0..CLKS_PER_BIT-1, and restart at 0 on every state change.
REQ-020 fifo_rd_en SHALL never assert while fifo_empty=1 or outside FETCH; exactly one pop per frame.
REQ-021 Deasserting tx_enable mid-frame SHALL NOT abort the frame; it only blocks the next FETCH.
REQ-022 A change on fifo_empty after FETCH SHALL NOT affect the current frame.
REQ-023 tx SHALL be 1 in IDLE, FETCH and LOAD.

Reset
REQ-024 With rst=0: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, counters and shift register cleared, all immediately and asynchronously.
REQ-025 Reset mid-frame SHALL abandon the frame and drive tx high at once; the popped word is lost.
REQ-026 After rst returns to 1, the first FETCH SHALL occur no earlier than the second rising edge.

Configuration
REQ-027 Macro UART_PARITY_EN defined: a PARITY state SHALL sit between DATA and STOP and send the even-parity bit (XOR of the data) for CLKS_PER_BIT cycles; frame = (DATA_W+3)*CLKS_PER_BIT cycles.
REQ-028 Macro UART_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, DATA goes straight to STOP, and frame = (DATA_W+2)*CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4, DATA_W=8)
REQ-029 Load 0xA5 into the FIFO model, tx_enable=1 -> one fifo_rd_en pulse; tx = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles; frame_done once; busy high 42 cycles (40 frame cycles + FETCH + LOAD; 46 with parity).
REQ-030 Three words 0x00, 0xFF, 0x3C queued -> three frames in order; exactly 1 IDLE cycle between them; 3 pops total.
REQ-031 fifo_empty=1 for 100 cycles with tx_enable=1 -> fifo_rd_en never asserts, tx=1, busy=0.
REQ-032 Drop tx_enable in the middle of a 0x55 frame with 2 words queued -> current frame completes; no further pop until tx_enable=1.
REQ-033 Assert rst=0 during DATA bit 3 -> tx=1 and busy=0 within the same cycle; after release, the next frame sends the next FIFO word.
REQ-034 With UART_PARITY_EN, send 0x07 -> parity bit 1 (odd count of ones); send 0x03 -> parity bit 0.
